id_check: RTL and testbench
===========================

Name: id_check

Overview:
- Login front end: collects a 4-digit player ID from the keypad and searches the ID ROM for it.
- Recognises the guest ID without a ROM search.
- Presents the matched internal player slot to the downstream password checker through ID_IDcheck, IDmatched and isGuest_ID.
- Holds the match until the password checker pulses Logout_ID. Enforces a lockout after repeated unknown IDs.

Parameters:
- NUM_IDS, 7, number of valid ROM entries searched (addresses 0..NUM_IDS-1); legal range 1..7.
- GUEST_ID, 16'h0000, 4-digit code that logs in as guest.
- GUEST_SLOT, 3'd7, internal player ID reported for guest.
- MAX_FAIL, 3, consecutive unknown-ID attempts that trigger lockout.
- LOCK_CYCLES, 16, clocks spent locked.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- PlayerID  in  4  keypad digit.
- ID_enter  in  1  digit-valid strobe, one clock per digit.
- Logout_ID  in  1  one-clock pulse from the password checker: release the current ID.
- ID_ROMdata  in  16  ID ROM read data.
- ID_ROMaddr  out  5  ID ROM address.
- ID_IDcheck  out  3  matched internal player slot.
- IDmatched  out  1  level: a valid ID is held.
- isGuest_ID  out  1  level: the held ID is the guest.
- IDerror  out  1  one-clock pulse: unknown ID.
- Locked  out  1  level: lockout active, keypad ignored.

Behaviour:
- Reset: all outputs are 0. Internal state: ID register 0, index 0, fail_count 0, lock counter 0, state DIGIT1.
- Reset asserted in any state, including mid-search or locked, aborts the operation and restores these values on the same edge.
- DIGIT1..DIGIT4: on an edge with ID_enter=1, PlayerID is stored into id_reg.
  - Digit order, first to last: [15:12], [11:8], [7:4], [3:0].
  - The FSM advances one state per accepted digit; with ID_enter=0 it holds.
  - DIGIT4 then moves to GUEST_CHK.
- GUEST_CHK (1 clk):
  - If id_reg==GUEST_ID: ID_IDcheck<=GUEST_SLOT, isGuest_ID<=1, IDmatched<=1, fail_count<=0, go to MATCHED.
  - Otherwise: index<=0, go to FETCH.
- Search loop, 5 clocks per entry:
  - FETCH: ID_ROMaddr<={2'b00,index}.
  - ROMCYCLE1, ROMCYCLE2: wait for ROM read latency.
  - CATCH: register ID_ROMdata.
  - COMPARE, on match: ID_IDcheck<=index, isGuest_ID<=0, IDmatched<=1, fail_count<=0, go to MATCHED.
  - COMPARE, on mismatch with index<NUM_IDS-1: index+1, go to FETCH.
  - COMPARE, on mismatch with index==NUM_IDS-1: IDerror<=1 for one clock, fail_count+1. Go to LOCKED if the new count equals MAX_FAIL, else DIGIT1.
- Latency: let E be the edge that captures digit 4.
  - Guest: IDmatched rises at E+1.
  - ROM entry k: IDmatched rises at E+6+5k.
  - Unknown ID: IDerror is high after edge E+6+5(NUM_IDS-1).
- MATCHED:
  - Outputs hold; ID_enter is ignored.
  - Logout_ID=1: IDmatched, isGuest_ID and ID_IDcheck clear to 0 on that edge, go to DIGIT1.
- LOCKED:
  - Locked=1, lock counter cleared on entry, ID_enter ignored.
  - After LOCK_CYCLES clocks: Locked<=0, fail_count<=0, go to DIGIT1.
- ID_enter in GUEST_CHK, FETCH..COMPARE or LOCKED is ignored and its digit discarded.
- Logout_ID outside MATCHED is ignored.
- fail_count saturates at MAX_FAIL. Any match, guest included, clears it.
- ID_ROMaddr holds its last value outside FETCH.

Test Plan:
- Reset check: rst=1 mid-search (in ROMCYCLE2) -> next cycle all outputs 0 and FSM in DIGIT1; a fresh 4-digit entry is then accepted.
- ROM match: ROM[3]=16'h1234; enter 1,2,3,4 -> IDmatched=1, ID_IDcheck=3, isGuest_ID=0 at E+21. Logout_ID pulse -> all three outputs 0 the next cycle.
- Guest: enter 0,0,0,0 -> at E+1 IDmatched=1, isGuest_ID=1, ID_IDcheck=7; ID_ROMaddr unchanged from reset (0).
- Unknown ID: no ROM entry equals 16'h9999; enter 9,9,9,9 -> single-cycle IDerror after E+36 (NUM_IDS=7); IDmatched stays 0; FSM returns to DIGIT1.
- Lockout: three consecutive unknown IDs -> Locked=1 for 16 clocks; digits entered meanwhile are discarded; afterwards a valid ID (1,2,3,4) matches normally.
- Ignored inputs: while in MATCHED, ID_enter pulses with digit 5 leave ID_IDcheck unchanged. Logout_ID pulsed in DIGIT2 has no effect and the 4-digit entry completes normally.

Source files
------------

// File: rtl/id_check.sv
// id_check: login front end for the player terminal.
// Collects a 4-digit player ID from the keypad, recognises the guest code
// directly, otherwise walks the ID ROM (5 clocks per entry) looking for the
// code. A matching ID is held for the password checker until it pulses
// Logout_ID. A run of unknown IDs locks the keypad for LOCK_CYCLES clocks.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   PlayerID    keypad digit, captured when ID_enter is high
//   ID_enter    one-clock strobe per digit
//   Logout_ID   one-clock release pulse from the password checker
//   ID_ROMdata  ID ROM read data (read latency covered by two wait states)
//   ID_ROMaddr  ID ROM address, holds between fetches
//   ID_IDcheck  matched internal player slot
//   IDmatched   level: a valid ID is held
//   isGuest_ID  level: the held ID is the guest
//   IDerror     one-clock pulse: unknown ID
//   Locked      level: lockout active, keypad ignored
module id_check #(
    parameter int          NUM_IDS     = 7,
    parameter logic [15:0] GUEST_ID    = 16'h0000,
    parameter logic [2:0]  GUEST_SLOT  = 3'd7,
    parameter int          MAX_FAIL    = 3,
    parameter int          LOCK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  PlayerID,
    input  logic        ID_enter,
    input  logic        Logout_ID,
    input  logic [15:0] ID_ROMdata,
    output logic [4:0]  ID_ROMaddr,
    output logic [2:0]  ID_IDcheck,
    output logic        IDmatched,
    output logic        isGuest_ID,
    output logic        IDerror,
    output logic        Locked
);

    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [2:0]    LAST_IDX  = 3'(NUM_IDS - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

    typedef enum logic [3:0] {
        DIGIT1, DIGIT2, DIGIT3, DIGIT4, GUEST_CHK,
        FETCH, ROMCYCLE1, ROMCYCLE2, CATCH, COMPARE,
        MATCHED, LOCKED
    } state_t;

    state_t        state_r,   state_nxt;
    logic [15:0]   id_r,      id_nxt;
    logic [2:0]    index_r,   index_nxt;
    logic [15:0]   data_r,    data_nxt;
    logic [FW-1:0] fail_r,    fail_nxt;
    logic [FW-1:0] fail_inc_s;
    logic [LW-1:0] lock_r,    lock_nxt;
    logic [4:0]    addr_r,    addr_nxt;
    logic [2:0]    slot_r,    slot_nxt;
    logic          matched_r, matched_nxt;
    logic          guest_r,   guest_nxt;
    logic          error_r,   error_nxt;
    logic          locked_r,  locked_nxt;

    // Next-state and next-output computation for the login sequencer.
    always_comb begin
        state_nxt   = state_r;
        id_nxt      = id_r;
        index_nxt   = index_r;
        data_nxt    = data_r;
        fail_nxt    = fail_r;
        lock_nxt    = lock_r;
        addr_nxt    = addr_r;
        slot_nxt    = slot_r;
        matched_nxt = matched_r;
        guest_nxt   = guest_r;
        error_nxt   = 1'b0;
        locked_nxt  = locked_r;
        // Saturating increment used when an attempt turns out unknown.
        fail_inc_s  = (fail_r == FAIL_MAX) ? fail_r : fail_r + FW'(1);

        case (state_r)
            DIGIT1: begin
                if (ID_enter) begin
                    id_nxt[15:12] = PlayerID;
                    state_nxt     = DIGIT2;
                end else begin
                    state_nxt = DIGIT1;
                end
            end
            DIGIT2: begin
                if (ID_enter) begin
                    id_nxt[11:8] = PlayerID;
                    state_nxt    = DIGIT3;
                end else begin
                    state_nxt = DIGIT2;
                end
            end
            DIGIT3: begin
                if (ID_enter) begin
                    id_nxt[7:4] = PlayerID;
                    state_nxt   = DIGIT4;
                end else begin
                    state_nxt = DIGIT3;
                end
            end
            DIGIT4: begin
                if (ID_enter) begin
                    id_nxt[3:0] = PlayerID;
                    state_nxt   = GUEST_CHK;
                end else begin
                    state_nxt = DIGIT4;
                end
            end
            GUEST_CHK: begin
                if (id_r == GUEST_ID) begin
                    slot_nxt    = GUEST_SLOT;
                    guest_nxt   = 1'b1;
                    matched_nxt = 1'b1;
                    fail_nxt    = '0;
                    state_nxt   = MATCHED;
                end else begin
                    index_nxt = 3'd0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                addr_nxt  = {2'b00, index_r};
                state_nxt = ROMCYCLE1;
            end
            ROMCYCLE1: state_nxt = ROMCYCLE2;
            ROMCYCLE2: state_nxt = CATCH;
            CATCH: begin
                data_nxt  = ID_ROMdata;
                state_nxt = COMPARE;
            end
            COMPARE: begin
                if (data_r == id_r) begin
                    slot_nxt    = index_r;
                    guest_nxt   = 1'b0;
                    matched_nxt = 1'b1;
                    fail_nxt    = '0;
                    state_nxt   = MATCHED;
                end else if (index_r < LAST_IDX) begin
                    index_nxt = index_r + 3'd1;
                    state_nxt = FETCH;
                end else begin
                    error_nxt = 1'b1;
                    fail_nxt  = fail_inc_s;
                    if (fail_inc_s == FAIL_MAX) begin
                        locked_nxt = 1'b1;
                        lock_nxt   = '0;
                        state_nxt  = LOCKED;
                    end else begin
                        state_nxt = DIGIT1;
                    end
                end
            end
            MATCHED: begin
                if (Logout_ID) begin
                    matched_nxt = 1'b0;
                    guest_nxt   = 1'b0;
                    slot_nxt    = 3'd0;
                    state_nxt   = DIGIT1;
                end else begin
                    state_nxt = MATCHED;
                end
            end
            LOCKED: begin
                // Locked was raised on the entry edge, so LOCK_CYCLES
                // clocks in this state give LOCK_CYCLES clocks of Locked.
                if (lock_r == LOCK_LAST) begin
                    locked_nxt = 1'b0;
                    fail_nxt   = '0;
                    state_nxt  = DIGIT1;
                end else begin
                    lock_nxt  = lock_r + LW'(1);
                    state_nxt = LOCKED;
                end
            end
            default: state_nxt = DIGIT1;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= DIGIT1;
            id_r      <= 16'h0000;
            index_r   <= 3'd0;
            data_r    <= 16'h0000;
            fail_r    <= '0;
            lock_r    <= '0;
            addr_r    <= 5'd0;
            slot_r    <= 3'd0;
            matched_r <= 1'b0;
            guest_r   <= 1'b0;
            error_r   <= 1'b0;
            locked_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            id_r      <= id_nxt;
            index_r   <= index_nxt;
            data_r    <= data_nxt;
            fail_r    <= fail_nxt;
            lock_r    <= lock_nxt;
            addr_r    <= addr_nxt;
            slot_r    <= slot_nxt;
            matched_r <= matched_nxt;
            guest_r   <= guest_nxt;
            error_r   <= error_nxt;
            locked_r  <= locked_nxt;
        end
    end

    assign ID_ROMaddr = addr_r;
    assign ID_IDcheck = slot_r;
    assign IDmatched  = matched_r;
    assign isGuest_ID = guest_r;
    assign IDerror    = error_r;
    assign Locked     = locked_r;

endmodule

// File: tb/tb_id_check.sv
// Self-checking bench for id_check: fixed vector table, hand-written corner
// sequences (reset mid-search, lockout, ignored inputs) and random IDs
// checked against a behavioural model of the login rules.
module tb_id_check;

    localparam int          NUM_IDS    = 7;
    localparam logic [15:0] GUEST_ID   = 16'h0000;
    localparam logic [2:0]  GUEST_SLOT = 3'd7;
    localparam int          MAX_FAIL   = 3;
    localparam int          LOCK_CYC   = 16;

    logic        clk;
    logic        rst;
    logic [3:0]  PlayerID;
    logic        ID_enter;
    logic        Logout_ID;
    logic [15:0] ID_ROMdata;
    logic [4:0]  ID_ROMaddr;
    logic [2:0]  ID_IDcheck;
    logic        IDmatched;
    logic        isGuest_ID;
    logic        IDerror;
    logic        Locked;

    logic [15:0] rom [0:31];

    int tests;
    int fails;
    int fail_m;   // model: consecutive unknown-ID count

    typedef struct {
        logic [15:0] code;
        logic        exp_m;
        logic [2:0]  exp_slot;
        logic        exp_g;
        int          exp_lat;
    } vec_t;

    vec_t tbl [7];

    id_check #(
        .NUM_IDS(NUM_IDS), .GUEST_ID(GUEST_ID), .GUEST_SLOT(GUEST_SLOT),
        .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYC)
    ) dut (
        .clk(clk), .rst(rst), .PlayerID(PlayerID), .ID_enter(ID_enter),
        .Logout_ID(Logout_ID), .ID_ROMdata(ID_ROMdata), .ID_ROMaddr(ID_ROMaddr),
        .ID_IDcheck(ID_IDcheck), .IDmatched(IDmatched), .isGuest_ID(isGuest_ID),
        .IDerror(IDerror), .Locked(Locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM with one clock of read latency.
    always @(posedge clk) ID_ROMdata <= rom[ID_ROMaddr];

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input bit ok, input string nm, input int act, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: guest code first, then first ROM entry among 0..NUM_IDS-1.
    task automatic model(input logic [15:0] code, output logic m,
                         output logic [2:0] slot, output logic g, output int lat);
        m = 1'b0; slot = 3'd0; g = 1'b0; lat = 6 + 5 * (NUM_IDS - 1);
        if (code == GUEST_ID) begin
            m = 1'b1; slot = GUEST_SLOT; g = 1'b1; lat = 1;
        end else begin
            for (int k = NUM_IDS - 1; k >= 0; k--) begin
                if (rom[k] == code) begin
                    m = 1'b1; slot = 3'(k); lat = 6 + 5 * k;
                end
            end
        end
    endtask

    task automatic enter_digits(input logic [15:0] code);
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            PlayerID = code[15 - 4 * d -: 4];
            ID_enter = 1'b1;
        end
        @(negedge clk);
        ID_enter = 1'b0;
    endtask

    task automatic logout_check(input string nm);
        @(negedge clk);
        Logout_ID = 1'b1;
        @(negedge clk);
        Logout_ID = 1'b0;
        check(IDmatched == 1'b0, {nm, "_logout_matched"}, int'(IDmatched), 0);
        check(isGuest_ID == 1'b0, {nm, "_logout_guest"}, int'(isGuest_ID), 0);
        check(ID_IDcheck == 3'd0, {nm, "_logout_slot"}, int'(ID_IDcheck), 0);
    endtask

    // Called at the negedge just after the edge that captured digit 4.
    task automatic observe(input logic exp_m, input logic [2:0] exp_slot,
                           input logic exp_g, input int exp_lat,
                           input bit do_logout, input string nm);
        int m_at = -1;
        int e_at = -1;
        int e_cnt = 0;
        int l_at = -1;
        int l_cnt = 0;
        logic [2:0] slot_seen = 3'd0;
        logic guest_seen = 1'b0;
        for (int n = 1; n <= 37; n++) begin
            @(negedge clk);
            if (IDmatched && m_at < 0) begin
                m_at = n; slot_seen = ID_IDcheck; guest_seen = isGuest_ID;
            end
            if (IDerror) begin
                e_cnt++;
                if (e_at < 0) e_at = n;
            end
            if (Locked) begin
                l_cnt++;
                if (l_at < 0) l_at = n;
            end
        end
        if (exp_m) begin
            check(m_at == exp_lat, {nm, "_match_latency"}, m_at, exp_lat);
            check(slot_seen == exp_slot, {nm, "_slot"}, int'(slot_seen), int'(exp_slot));
            check(guest_seen == exp_g, {nm, "_guest"}, int'(guest_seen), int'(exp_g));
            check(e_cnt == 0, {nm, "_no_error"}, e_cnt, 0);
            fail_m = 0;
            if (do_logout) logout_check(nm);
        end else begin
            check(e_at == exp_lat, {nm, "_error_time"}, e_at, exp_lat);
            check(e_cnt == 1, {nm, "_error_pulses"}, e_cnt, 1);
            check(m_at == -1, {nm, "_no_match"}, m_at, -1);
            fail_m++;
            if (fail_m == MAX_FAIL) begin
                check(l_at == exp_lat, {nm, "_lock_start"}, l_at, exp_lat);
                // Keep pressing digits while locked; they must be discarded.
                for (int b = 0; b < 40 && Locked; b++) begin
                    PlayerID = 4'd9;
                    ID_enter = 1'b1;
                    @(negedge clk);
                    if (Locked) l_cnt++;
                end
                ID_enter = 1'b0;
                check(l_cnt == LOCK_CYC, {nm, "_lock_cycles"}, l_cnt, LOCK_CYC);
                fail_m = 0;
            end else begin
                check(l_at == -1, {nm, "_no_lock"}, l_at, -1);
            end
        end
    endtask

    initial begin
        logic        rm;
        logic [2:0]  rslot;
        logic        rg;
        int          rlat;
        logic [15:0] code;
        int          sel;

        tests = 0; fails = 0; fail_m = 0;
        for (int i = 0; i < 32; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h4321; rom[1] = 16'h1111; rom[2] = 16'h5678;
        rom[3] = 16'h1234; rom[4] = 16'hBEEF; rom[5] = 16'h1234;
        rom[6] = 16'h0F0F; rom[7] = 16'h2222;   // entry 7 lies beyond NUM_IDS

        tbl[0] = '{16'h1234, 1'b1, 3'd3, 1'b0, 21};
        tbl[1] = '{16'h0000, 1'b1, 3'd7, 1'b1, 1};
        tbl[2] = '{16'h4321, 1'b1, 3'd0, 1'b0, 6};
        tbl[3] = '{16'h0F0F, 1'b1, 3'd6, 1'b0, 36};
        tbl[4] = '{16'h2222, 1'b0, 3'd0, 1'b0, 36};
        tbl[5] = '{16'hBEEF, 1'b1, 3'd4, 1'b0, 26};
        tbl[6] = '{16'h1111, 1'b1, 3'd1, 1'b0, 11};

        rst = 1'b1; PlayerID = 4'd0; ID_enter = 1'b0; Logout_ID = 1'b0;
        repeat (3) @(negedge clk);
        check(IDmatched == 1'b0, "reset_matched", int'(IDmatched), 0);
        check(isGuest_ID == 1'b0, "reset_guest", int'(isGuest_ID), 0);
        check(ID_IDcheck == 3'd0, "reset_slot", int'(ID_IDcheck), 0);
        check(IDerror == 1'b0, "reset_error", int'(IDerror), 0);
        check(Locked == 1'b0, "reset_locked", int'(Locked), 0);
        check(ID_ROMaddr == 5'd0, "reset_addr", int'(ID_ROMaddr), 0);
        rst = 1'b0;

        // Guest straight after reset: no ROM access at all.
        enter_digits(16'h0000);
        observe(1'b1, 3'd7, 1'b1, 1, 1'b1, "guest");
        check(ID_ROMaddr == 5'd0, "guest_addr_untouched", int'(ID_ROMaddr), 0);

        // Two unknowns, then reset in ROMCYCLE2 of entry 3 of a search.
        enter_digits(16'h9999);
        observe(1'b0, 3'd0, 1'b0, 36, 1'b1, "unk_a");
        enter_digits(16'h9999);
        observe(1'b0, 3'd0, 1'b0, 36, 1'b1, "unk_b");
        enter_digits(16'h1234);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fail_m = 0;
        check(IDmatched == 1'b0, "midreset_matched", int'(IDmatched), 0);
        check(IDerror == 1'b0, "midreset_error", int'(IDerror), 0);
        check(Locked == 1'b0, "midreset_locked", int'(Locked), 0);
        check(ID_ROMaddr == 5'd0, "midreset_addr", int'(ID_ROMaddr), 0);
        // Fail count restarted: one more unknown must not lock.
        enter_digits(16'h9999);
        observe(1'b0, 3'd0, 1'b0, 36, 1'b1, "post_reset_unk");
        enter_digits(16'h1234);
        observe(1'b1, 3'd3, 1'b0, 21, 1'b1, "post_reset_match");

        for (int i = 0; i < 7; i++) begin
            enter_digits(tbl[i].code);
            observe(tbl[i].exp_m, tbl[i].exp_slot, tbl[i].exp_g,
                    tbl[i].exp_lat, 1'b1, $sformatf("tbl%0d", i));
        end

        // Lockout after three consecutive unknowns, then a normal login.
        for (int i = 0; i < 3; i++) begin
            enter_digits(16'h9999);
            observe(1'b0, 3'd0, 1'b0, 36, 1'b1, $sformatf("lock_unk%0d", i));
        end
        enter_digits(16'h1234);
        observe(1'b1, 3'd3, 1'b0, 21, 1'b1, "after_lock");

        // Digits pressed while MATCHED are ignored.
        enter_digits(16'h1234);
        observe(1'b1, 3'd3, 1'b0, 21, 1'b0, "hold");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            PlayerID = 4'd5; ID_enter = 1'b1;
            @(negedge clk);
            ID_enter = 1'b0;
        end
        check(ID_IDcheck == 3'd3, "hold_slot", int'(ID_IDcheck), 3);
        check(IDmatched == 1'b1, "hold_matched", int'(IDmatched), 1);
        logout_check("hold");

        // Logout pulse during DIGIT2 has no effect.
        @(negedge clk);
        PlayerID = 4'd1; ID_enter = 1'b1;
        @(negedge clk);
        ID_enter = 1'b0; Logout_ID = 1'b1;
        @(negedge clk);
        Logout_ID = 1'b0;
        for (int d = 1; d < 4; d++) begin
            @(negedge clk);
            PlayerID = 4'(d + 1); ID_enter = 1'b1;
        end
        @(negedge clk);
        ID_enter = 1'b0;
        observe(1'b1, 3'd3, 1'b0, 21, 1'b1, "logout_in_digit2");

        // Random IDs against the reference model.
        for (int i = 0; i < 25; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) code = GUEST_ID;
            else if (sel <= 6) code = rom[$urandom_range(0, 7)];
            else code = 16'($urandom);
            model(code, rm, rslot, rg, rlat);
            enter_digits(code);
            observe(rm, rslot, rg, rlat, 1'b1, $sformatf("rnd%0d_%04h", i, code));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
